// File: rtl/mem_stage_if.sv
// MEM stage port bundle: EX handshake, data bus and writeback slot.
// The stage uses the slave view; its environment drives the master view.
interface mem_stage_if #(
  parameter int RF_AW = 5,
  parameter int AW    = 32
);
  logic             flush;
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_we;
  logic [RF_AW-1:0] ex_waddr;
  logic [31:0]      ex_wdata;
  logic             ex_mem_rd;
  logic             ex_mem_wr;
  logic [1:0]       ex_mem_size;
  logic             ex_mem_sext;
  logic [31:0]      ex_sdata;

  logic             bus_req;
  logic             bus_we;
  logic [AW-1:0]    bus_addr;
  logic [31:0]      bus_wdata;
  logic [3:0]       bus_be;
  logic             bus_ack;
  logic [31:0]      bus_rdata;

  logic             mem_valid;
  logic             mem_we;
  logic [RF_AW-1:0] mem_waddr;
  logic [31:0]      mem_wdata;
  logic             mem_err;

  modport slave (
    input  flush, ex_valid, ex_we, ex_waddr, ex_wdata,
    input  ex_mem_rd, ex_mem_wr, ex_mem_size, ex_mem_sext,
    input  ex_sdata, bus_ack, bus_rdata,
    output ex_ready, bus_req, bus_we, bus_addr, bus_wdata,
    output bus_be, mem_valid, mem_we, mem_waddr, mem_wdata,
    output mem_err
  );

  modport master (
    output flush, ex_valid, ex_we, ex_waddr, ex_wdata,
    output ex_mem_rd, ex_mem_wr, ex_mem_size, ex_mem_sext,
    output ex_sdata, bus_ack, bus_rdata,
    input  ex_ready, bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_be, mem_valid, mem_we, mem_waddr, mem_wdata,
    input  mem_err
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers ALU results toward writeback and
// performs byte/half/word loads and stores over a req/ack bus.
module mem_stage #(
  parameter int RF_AW    = 5,
  parameter int AW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_stage_if.slave     io
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             op_rd_q, op_rd_d;
  logic             op_we_q, op_we_d;
  logic [RF_AW-1:0] op_wa_q, op_wa_d;
  logic [1:0]       op_sz_q, op_sz_d;
  logic             op_sx_q, op_sx_d;
  logic [1:0]       op_off_q, op_off_d;

  logic             req_q, req_d;
  logic             bwe_q, bwe_d;
  logic [AW-1:0]    badr_q, badr_d;
  logic [31:0]      bwd_q, bwd_d;
  logic [3:0]       be_q, be_d;

  logic             mv_q, mv_d;
  logic             mwe_q, mwe_d;
  logic [RF_AW-1:0] mwa_q, mwa_d;
  logic [31:0]      mwd_q, mwd_d;
  logic             merr_q, merr_d;

  logic             accept;
  logic             is_mem;
  logic             bad;
  logic [1:0]       off;
  logic [3:0]       be_c;
  logic [31:0]      wd_c;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic [31:0]      ld_v;

  assign io.ex_ready  = (state_q == IDLE);
  assign io.bus_req   = req_q;
  assign io.bus_we    = bwe_q;
  assign io.bus_addr  = badr_q;
  assign io.bus_wdata = bwd_q;
  assign io.bus_be    = be_q;
  assign io.mem_valid = mv_q;
  assign io.mem_we    = mwe_q;
  assign io.mem_waddr = mwa_q;
  assign io.mem_wdata = mwd_q;
  assign io.mem_err   = merr_q;

  assign accept = io.ex_valid && io.ex_ready;
  assign is_mem = io.ex_mem_rd || io.ex_mem_wr;
  assign off    = io.ex_wdata[1:0];

  // Decode size into lane enables, replicated store data and legality
  always_comb begin
    be_c = 4'h0;
    wd_c = io.ex_sdata;
    bad  = io.ex_mem_rd && io.ex_mem_wr;
    unique case (io.ex_mem_size)
      2'd0: begin
        be_c = 4'b0001 << off;
        wd_c = {4{io.ex_sdata[7:0]}};
      end
      2'd1: begin
        be_c = 4'b0011 << {off[1], 1'b0};
        wd_c = {2{io.ex_sdata[15:0]}};
        bad  = bad || off[0];
      end
      2'd2: begin
        be_c = 4'hF;
        bad  = bad || (off != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

  // Pick the addressed lane from read data and extend it
  always_comb begin
    ld_b = io.bus_rdata[{op_off_q, 3'b000} +: 8];
    ld_h = op_off_q[1] ? io.bus_rdata[31:16] : io.bus_rdata[15:0];
    unique case (op_sz_q)
      2'd0:    ld_v = {{24{op_sx_q & ld_b[7]}}, ld_b};
      2'd1:    ld_v = {{16{op_sx_q & ld_h[15]}}, ld_h};
      default: ld_v = io.bus_rdata;
    endcase
  end

  // Next-state, bus request and writeback slot
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    op_rd_d  = op_rd_q;
    op_we_d  = op_we_q;
    op_wa_d  = op_wa_q;
    op_sz_d  = op_sz_q;
    op_sx_d  = op_sx_q;
    op_off_d = op_off_q;
    req_d    = req_q;
    bwe_d    = bwe_q;
    badr_d   = badr_q;
    bwd_d    = bwd_q;
    be_d     = be_q;
    mv_d     = 1'b0;
    mwe_d    = 1'b0;
    merr_d   = 1'b0;
    mwa_d    = mwa_q;
    mwd_d    = mwd_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !io.flush) begin
          if (!is_mem) begin
            mv_d  = 1'b1;
            mwe_d = io.ex_we;
            mwa_d = io.ex_waddr;
            mwd_d = io.ex_wdata;
          end else if (bad) begin
            mv_d   = 1'b1;
            merr_d = 1'b1;
          end else begin
            state_d  = ACCESS;
            cnt_d    = '0;
            sq_d     = 1'b0;
            op_rd_d  = io.ex_mem_rd;
            op_we_d  = io.ex_we;
            op_wa_d  = io.ex_waddr;
            op_sz_d  = io.ex_mem_size;
            op_sx_d  = io.ex_mem_sext;
            op_off_d = off;
            req_d    = 1'b1;
            bwe_d    = io.ex_mem_wr;
            badr_d   = {io.ex_wdata[AW-1:2], 2'b00};
            bwd_d    = wd_c;
            be_d     = be_c;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        sq_d  = sq_q | io.flush;
        if (io.bus_ack || cnt_d == CW'(MAX_WAIT)) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!sq_d) begin
            mv_d  = 1'b1;
            mwa_d = op_wa_q;
            if (io.bus_ack) begin
              mwe_d = op_rd_q & op_we_q;
              mwd_d = op_rd_q ? ld_v : 32'h0;
            end else begin
              merr_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sq_q     <= 1'b0;
      op_rd_q  <= 1'b0;
      op_we_q  <= 1'b0;
      op_wa_q  <= '0;
      op_sz_q  <= 2'd0;
      op_sx_q  <= 1'b0;
      op_off_q <= 2'd0;
      req_q    <= 1'b0;
      bwe_q    <= 1'b0;
      badr_q   <= '0;
      bwd_q    <= 32'h0;
      be_q     <= 4'h0;
      mv_q     <= 1'b0;
      mwe_q    <= 1'b0;
      mwa_q    <= '0;
      mwd_q    <= 32'h0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
      op_rd_q  <= op_rd_d;
      op_we_q  <= op_we_d;
      op_wa_q  <= op_wa_d;
      op_sz_q  <= op_sz_d;
      op_sx_q  <= op_sx_d;
      op_off_q <= op_off_d;
      req_q    <= req_d;
      bwe_q    <= bwe_d;
      badr_q   <= badr_d;
      bwd_q    <= bwd_d;
      be_q     <= be_d;
      mv_q     <= mv_d;
      mwe_q    <= mwe_d;
      mwa_q    <= mwa_d;
      mwd_q    <= mwd_d;
      merr_q   <= merr_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected writeback events are queued by
// the stimulus and checked every cycle against the DUT.
module tb_mem_stage;
  localparam int MW = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if #(.RF_AW(5), .AW(32)) mif ();

  mem_stage #(.RF_AW(5), .AW(32), .MAX_WAIT(MW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (mif)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        err;
    logic        cw;
  } exp_t;
  exp_t expq[$];

  logic [3:0]  last_be;
  logic [31:0] last_bwd;
  logic        last_bwe;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Spec-level model helpers
  function automatic logic legal(input logic rd, input logic wr,
                                 input logic [1:0] sz,
                                 input logic [31:0] a);
    if (sz == 2'd3) return 1'b0;
    if (rd && wr) return 1'b0;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b0;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz,
                                        input logic [31:0] a);
    int o;
    o = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << o);
    if (sz == 2'd1) return 4'(3 << (o & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz,
                                         input logic [31:0] sd);
    if (sz == 2'd0) return 32'(sd[7:0] * 32'h0101_0101);
    if (sz == 2'd1) return 32'(sd[15:0] * 32'h0001_0001);
    return sd;
  endfunction

  function automatic logic [31:0] load_val(input logic [1:0] sz,
                                           input logic sx,
                                           input logic [31:0] a,
                                           input logic [31:0] rdt);
    int o;
    logic [31:0] v;
    o = int'(a % 4);
    if (sz == 2'd0) begin
      v = (rdt >> (8 * o)) & 32'hFF;
      if (sx && v >= 128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (rdt >> (8 * (o & 2))) & 32'hFFFF;
      if (sx && v >= 32768) v = v - 32'd65536;
    end else begin
      v = rdt;
    end
    return v;
  endfunction

  // Per-cycle writeback comparison
  always @(negedge clk) begin
    exp_t e;
    if (chk_on && reset_n === 1'b1) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("wb_valid", 32'(mif.mem_valid), 32'd1);
        chk("wb_we", 32'(mif.mem_we), 32'(e.we));
        chk("wb_err", 32'(mif.mem_err), 32'(e.err));
        if (e.we) chk("wb_waddr", 32'(mif.mem_waddr), 32'(e.wa));
        if (e.cw) chk("wb_wdata", mif.mem_wdata, e.wd);
      end else begin
        chk("idle_valid", 32'(mif.mem_valid), 32'd0);
        chk("idle_we", 32'(mif.mem_we), 32'd0);
        chk("idle_err", 32'(mif.mem_err), 32'd0);
      end
      if (expq.size() > 0 && expq[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL wb_missed: event due cycle %0d not seen",
                 expq[0].cyc);
        void'(expq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr,
                        input logic [1:0] sz, input logic sx,
                        input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [31:0] sd);
    mif.ex_valid    = 1'b1;
    mif.ex_mem_rd   = rd;
    mif.ex_mem_wr   = wr;
    mif.ex_mem_size = sz;
    mif.ex_mem_sext = sx;
    mif.ex_we       = we;
    mif.ex_waddr    = wa;
    mif.ex_wdata    = wd;
    mif.ex_sdata    = sd;
  endtask

  task automatic clr_op();
    mif.ex_valid  = 1'b0;
    mif.ex_mem_rd = 1'b0;
    mif.ex_mem_wr = 1'b0;
  endtask

  task automatic alu(input logic we, input logic [4:0] wa,
                     input logic [31:0] wd);
    set_op(1'b0, 1'b0, 2'd2, 1'b0, we, wa, wd, 32'h0);
    chk("alu_ready", 32'(mif.ex_ready), 32'd1);
    step();
    expq.push_back('{cyc, we, wa, wd, 1'b0, 1'b1});
  endtask

  // fl: -1 none, -2 flush with accept in IDLE, k>=0 flush in ACCESS cycle k
  task automatic mem_op(input logic rd, input logic wr,
                        input logic [1:0] sz, input logic sx,
                        input logic [4:0] wa, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdt,
                        input int d, input int fl);
    int a0;
    logic [3:0] be;
    logic [31:0] bwd;
    bit sq;
    set_op(rd, wr, sz, sx, 1'b1, wa, a, sd);
    mif.flush = (fl == -2);
    step();
    a0 = cyc;
    clr_op();
    mif.flush = 1'b0;
    if (fl == -2) begin
      chk("flush_idle_req", 32'(mif.bus_req), 32'd0);
      chk("flush_idle_ready", 32'(mif.ex_ready), 32'd1);
      return;
    end
    if (!legal(rd, wr, sz, a)) begin
      expq.push_back('{a0, 1'b0, wa, 32'h0, 1'b1, 1'b0});
      chk("err_noreq", 32'(mif.bus_req), 32'd0);
      chk("err_ready", 32'(mif.ex_ready), 32'd1);
      return;
    end
    be  = exp_be(sz, a);
    bwd = exp_wd(sz, sd);
    for (int i = 0; i <= d; i++) begin
      chk("acc_req", 32'(mif.bus_req), 32'd1);
      chk("acc_ready", 32'(mif.ex_ready), 32'd0);
      chk("acc_we", 32'(mif.bus_we), 32'(wr));
      chk("acc_addr", mif.bus_addr, a & ~32'h3);
      chk("acc_be", 32'(mif.bus_be), 32'(be));
      if (wr) chk("acc_wdata", mif.bus_wdata, bwd);
      last_be  = mif.bus_be;
      last_bwd = mif.bus_wdata;
      last_bwe = mif.bus_we;
      if (i == fl) mif.flush = 1'b1;
      if (i == d) begin
        mif.bus_ack   = 1'b1;
        mif.bus_rdata = rdt;
      end
      step();
      mif.flush     = 1'b0;
      mif.bus_ack   = 1'b0;
      mif.bus_rdata = $urandom;
    end
    sq = (fl >= 0 && fl <= d);
    if (!sq)
      expq.push_back('{a0 + d + 1, rd, wa,
                       rd ? load_val(sz, sx, a, rdt) : 32'h0,
                       1'b0, 1'b1});
    chk("done_req", 32'(mif.bus_req), 32'd0);
    chk("done_ready", 32'(mif.ex_ready), 32'd1);
  endtask

  task automatic timeout_op();
    int a0;
    int n;
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9, 32'h100, 32'h0);
    step();
    a0 = cyc;
    clr_op();
    expq.push_back('{a0 + MW, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0});
    n = 0;
    while (mif.bus_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("to_cycles", n, MW);
    chk("to_err_lit", 32'(mif.mem_err), 32'd1);
    chk("to_ready", 32'(mif.ex_ready), 32'd1);
    mif.bus_ack   = 1'b1;
    mif.bus_rdata = 32'h5555_AAAA;
    step();
    mif.bus_ack = 1'b0;
    chk("late_ack_req", 32'(mif.bus_req), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mif.flush     = 1'b0;
    mif.bus_ack   = 1'b0;
    mif.bus_rdata = 32'h0;
    clr_op();
    mif.ex_mem_size = 2'd0;
    mif.ex_mem_sext = 1'b0;
    mif.ex_we       = 1'b0;
    mif.ex_waddr    = 5'd0;
    mif.ex_wdata    = 32'h0;
    mif.ex_sdata    = 32'h0;
    last_be  = 4'h0;
    last_bwd = 32'h0;
    last_bwe = 1'b0;

    #2 reset_n = 1'b0;
    #1;
    chk("rst_req", 32'(mif.bus_req), 32'd0);
    chk("rst_ready", 32'(mif.ex_ready), 32'd1);
    chk("rst_valid", 32'(mif.mem_valid), 32'd0);
    chk("rst_we", 32'(mif.mem_we), 32'd0);
    chk("rst_err", 32'(mif.mem_err), 32'd0);
    chk("rst_waddr", 32'(mif.mem_waddr), 32'd0);
    chk("rst_wdata", mif.mem_wdata, 32'd0);
    chk("rst_be", 32'(mif.bus_be), 32'd0);
    chk("rst_addr", mif.bus_addr, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    chk_on  = 1'b1;
    step();

    alu(1'b1, 5'd7, 32'h1234_5678);
    chk("alu_wdata_lit", mif.mem_wdata, 32'h1234_5678);
    chk("alu_waddr_lit", 32'(mif.mem_waddr), 32'd7);
    alu(1'b0, 5'd3, 32'hDEAD_BEEF);
    alu(1'b1, 5'd31, 32'h0000_0001);
    clr_op();
    step();

    mem_op(1'b1, 1'b0, 2'd0, 1'b1, 5'd4, 32'h0000_1003, 32'h0,
           32'h80FF_0000, 2, -1);
    chk("lb_wdata_lit", mif.mem_wdata, 32'hFFFF_FF80);
    chk("lb_be_lit", 32'(last_be), 32'b1000);
    chk("lb_we_lit", 32'(mif.mem_we), 32'd1);

    mem_op(1'b1, 1'b0, 2'd0, 1'b0, 5'd6, 32'h0000_2001, 32'h0,
           32'h1234_8A56, 0, -1);
    chk("lbu_wdata_lit", mif.mem_wdata, 32'h0000_008A);
    mem_op(1'b1, 1'b0, 2'd1, 1'b1, 5'd8, 32'h0000_3002, 32'h0,
           32'hF00D_1234, 1, -1);
    mem_op(1'b1, 1'b0, 2'd2, 1'b0, 5'd10, 32'h0000_0004, 32'h0,
           32'hCAFE_BABE, 0, -1);
    mem_op(1'b0, 1'b1, 2'd0, 1'b0, 5'd11, 32'h0000_0011,
           32'h0000_00A5, 32'h0, 1, -1);
    mem_op(1'b0, 1'b1, 2'd1, 1'b0, 5'd12, 32'h0000_0102,
           32'h0000_ABCD, 32'h0, 1, -1);
    chk("sh_bwd_lit", last_bwd, 32'hABCD_ABCD);
    chk("sh_be_lit", 32'(last_be), 32'b1100);
    chk("sh_bwe_lit", 32'(last_bwe), 32'd1);
    chk("sh_we_lit", 32'(mif.mem_we), 32'd0);
    mem_op(1'b0, 1'b1, 2'd2, 1'b0, 5'd13, 32'h0000_0008,
           32'h1122_3344, 32'h0, 0, -1);

    mem_op(1'b1, 1'b0, 2'd2, 1'b0, 5'd14, 32'h0000_0101, 32'h0,
           32'h0, 0, -1);
    chk("lw_mis_err_lit", 32'(mif.mem_err), 32'd1);
    clr_op();
    step();
    chk("lw_mis_err_gone", 32'(mif.mem_err), 32'd0);
    mem_op(1'b1, 1'b0, 2'd1, 1'b0, 5'd15, 32'h0000_0103, 32'h0,
           32'h0, 0, -1);
    mem_op(1'b1, 1'b0, 2'd3, 1'b0, 5'd16, 32'h0000_0000, 32'h0,
           32'h0, 0, -1);
    mem_op(1'b1, 1'b1, 2'd2, 1'b0, 5'd17, 32'h0000_0000, 32'h0,
           32'h0, 0, -1);
    clr_op();
    step();

    timeout_op();

    mem_op(1'b1, 1'b0, 2'd1, 1'b0, 5'd18, 32'h0000_0202, 32'h0,
           32'h8001_0000, 3, 1);
    mem_op(1'b1, 1'b0, 2'd0, 1'b0, 5'd19, 32'h0000_0300, 32'h0,
           32'h0000_0077, 2, 2);
    mem_op(1'b1, 1'b0, 2'd2, 1'b0, 5'd20, 32'h0000_0400, 32'h0,
           32'h0, 0, -2);
    step();

    set_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd21, 32'h0000_0040, 32'h0);
    step();
    clr_op();
    step();
    chk("pre_rst_req", 32'(mif.bus_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(mif.bus_req), 32'd0);
    chk("arst_ready", 32'(mif.ex_ready), 32'd1);
    chk("arst_valid", 32'(mif.mem_valid), 32'd0);
    chk("arst_we", 32'(mif.mem_we), 32'd0);
    chk("arst_err", 32'(mif.mem_err), 32'd0);
    chk("arst_be", 32'(mif.bus_be), 32'd0);
    chk("arst_bwe", 32'(mif.bus_we), 32'd0);
    chk("arst_wdata", mif.mem_wdata, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_req", 32'(mif.bus_req), 32'd0);

    alu(1'b1, 5'd2, 32'h0BAD_F00D);
    clr_op();
    step();
    step();
    chk("q_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Next-generation MEM pipeline stage of the CPU core; replaces the plain EX/MEM register.
- Registers the EX result into the writeback path and adds real data-memory access over a req/ack bus.
- Supports byte, halfword and word loads/stores with sign/zero extension, upstream stall, flush, misalignment detection and a bus timeout.
- Sits between the execute stage and register-file writeback.

Parameters:
- RF_AW, 5, register-file address width.
- AW, 32, bus byte-address width (AW >= 3).
- MAX_WAIT, 15, ACCESS-state cycles without ack before timeout (>= 1).
- Data width is fixed at 32 bits (4 byte lanes).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash current/incoming op.
- ex_valid  in  1  EX presents an op.
- ex_ready  out  1  stage accepts op; combinational, equals (state==IDLE).
- ex_we  in  1  op writes register file.
- ex_waddr  in  RF_AW  destination register.
- ex_wdata  in  32  ALU result; byte address for memory ops.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- ex_mem_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- ex_mem_sext  in  1  sign-extend load.
- ex_sdata  in  32  store data, right-aligned.
- bus_req  out  1  request.
- bus_we  out  1  write.
- bus_addr  out  AW  word-aligned address.
- bus_wdata  out  32  write data.
- bus_be  out  4  byte enables.
- bus_ack  in  1  single-cycle completion.
- bus_rdata  in  32  read data, valid with ack.
- mem_valid  out  1  writeback slot valid.
- mem_we  out  1  register write enable.
- mem_waddr  out  RF_AW  writeback register.
- mem_wdata  out  32  writeback data.
- mem_err  out  1  one-cycle error pulse (misaligned, illegal or timeout).

Behaviour:
- Reset: state=IDLE, wait counter=0. All outputs 0: mem_*, mem_err, bus_*. ex_ready=1.
- Reset asserted mid-access drops bus_req immediately and discards the op.
- Accept condition: ex_valid && ex_ready.
- Non-memory op (rd=wr=0): on the next edge mem_valid=1, mem_we=ex_we, mem_waddr=ex_waddr, mem_wdata=ex_wdata. Latency 1 cycle; throughput 1 op/cycle.
- Memory op is in error when any of: size=3; rd && wr; half with addr[0]=1; word with addr[1:0]!=0.
  - No bus access is made.
  - Next cycle: mem_valid=1, mem_we=0, mem_err=1.
- Legal memory op moves to ACCESS. Registered bus signals:
  - bus_req=1; bus_we=wr; bus_addr={addr[AW-1:2],2'b00}.
  - Byte: bus_be=4'b0001<<addr[1:0], bus_wdata={4{sdata[7:0]}}.
  - Half: bus_be=4'b0011<<{addr[1],1'b0}, bus_wdata={2{sdata[15:0]}}.
  - Word: bus_be=4'hF, bus_wdata=sdata.
  - Load uses the same bus_be rules.
- ACCESS:
  - bus_* held stable until ack; ex_ready=0; wait counter increments each cycle.
  - On ack: bus_req=0 and state=IDLE at the same edge. Next cycle mem_valid=1.
    - Load: mem_we=ex_we; data is the selected lane (addr[1:0] byte, addr[1] half, little-endian), extended per sext.
    - Store: mem_we=0, mem_wdata=0.
  - Total load latency = accept + ack wait + 1.
- Timeout: counter==MAX_WAIT with no ack → bus_req=0, state=IDLE, mem_valid=1, mem_we=0, mem_err=1. A late ack in IDLE is ignored.
- Flush:
  - In IDLE, squashes any op accepted that cycle: next mem_valid=0, no bus access.
  - In ACCESS, the bus transaction still runs to ack or timeout (no abort). A sticky squash flag forces mem_valid=0, mem_we=0, mem_err=0 on completion.
  - Ack in the same cycle as flush counts as squashed.
- Whenever mem_valid=0: mem_we=0, mem_err=0; mem_waddr/mem_wdata hold their last values.
- Idle cycle (no accept): mem_valid=0.

Test Plan:
- ALU op ex_we=1, waddr=7, wdata=32'h1234_5678 → next cycle mem_valid=1, mem_we=1, mem_waddr=7, mem_wdata=32'h1234_5678.
- LB sext=1, addr=0x...03, ack after 2 cycles with rdata=32'h80FF_0000 → bus_be=4'b1000, ex_ready=0 during wait, mem_wdata=32'hFFFF_FF80.
- SH addr=0x...02, sdata=32'h0000_ABCD → bus_we=1, bus_be=4'b1100, bus_wdata=32'hABCD_ABCD, mem_we=0.
- LW addr=0x...01 → no bus_req, mem_valid=1, mem_we=0, mem_err=1 for exactly one cycle.
- LW, ack never arrives, MAX_WAIT=15 → bus_req deasserts after 15 ACCESS cycles, mem_err=1, ex_ready returns 1.
- LHU in ACCESS, flush pulsed, ack 3 cycles later → mem_valid stays 0. Separately: reset_n low mid-ACCESS → all outputs 0 asynchronously.
